pc_sequencer: RTL
=================

# pc_sequencer

Parametrised program-counter sequencer for the small program counter design. It generalises the fixed 6-bit combinational adder path into a registered PC with configurable width and step. It supports relative branch, absolute jump, hold, and a bounded call/return stack. It sits between the instruction decoder (which drives `op`/`operand`) and the instruction memory address port (`pc`).

## Interface
- `WIDTH`, 6: PC and operand width in bits (2..16).
- `STEP`, 1: increment added for INC and for the return address, taken modulo 2^WIDTH (must be less than 2^WIDTH).
- `RESET_PC`, 0: PC value loaded on reset.
- `STACK_DEPTH`, 4: number of return-address entries (1..16).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low; overrides every other input.
- `en`  in  1  advance enable; when 0, all state holds.
- `op`  in  3  operation: 000 INC, 001 BRANCH, 010 JUMP, 011 CALL, 100 RET, 101 HOLD, 110/111 reserved (treated as HOLD).
- `operand`  in  WIDTH  BRANCH: signed two's-complement offset; JUMP/CALL: absolute target; ignored otherwise.
- `pc`  out  WIDTH  current program counter, registered.
- `wrap`  out  1  one-cycle pulse: the last PC update crossed the modulo-2^WIDTH boundary.
- `stack_empty`  out  1  return stack holds 0 entries.
- `stack_full`  out  1  return stack holds STACK_DEPTH entries.
- `err`  out  1  sticky: push to a full stack or pop from an empty stack; cleared only by reset.

## Operation
- Priority per edge: `rst_n`=0, then `en`=0 (hold everything, `wrap` goes to 0), then `op`.
- INC: `pc` <= (pc+STEP) mod 2^WIDTH. Set `wrap` when the unsigned sum carries out.
- BRANCH: `pc` <= (pc + sext(operand)) mod 2^WIDTH. Set `wrap` when the exact signed result is <0 or >2^WIDTH-1.
- JUMP: `pc` <= operand; `wrap`=0.
- CALL, stack not full: push (pc+STEP) mod 2^WIDTH, `pc` <= operand, depth+1. `wrap`=0; the return-address carry is not flagged.
- CALL, stack full: no push and no jump; behave exactly as INC (including `wrap`); `err` <= 1.
- RET, stack not empty: `pc` <= top entry, pop, depth-1, `wrap`=0.
- RET, stack empty: behave exactly as INC; `err` <= 1.
- HOLD and reserved ops: `pc` and stack unchanged; `wrap`=0; no error.
- Stack is LIFO, implemented as an entry array plus a depth counter of width clog2(STACK_DEPTH+1).
- Flags are derived from the registered depth: `stack_empty` = (depth==0), `stack_full` = (depth==STACK_DEPTH).
- Entries above the depth counter are don't-care and are never observable on `pc`.
- All arithmetic is modulo 2^WIDTH. No output is ever X after the first reset edge.

## Timing
- Reset values, one edge after `rst_n`=0 is sampled: `pc`=RESET_PC, `wrap`=0, `stack_empty`=1, `stack_full`=0, `err`=0, depth=0.
- Before the first reset edge, outputs are undefined.
- Reset asserted mid-sequence (including during a CALL/RET cycle) discards the operation; the reset values appear after that edge.
- Latency: `op`/`operand` sampled at edge N with `en`=1 are reflected on `pc`, `wrap`, stack flags and `err` after edge N. There is no combinational input-to-output path.
- `wrap` is high for exactly the cycle following the wrapping edge. Back-to-back wrapping ops give consecutive pulses.
- Ops are single-cycle with no handshake. A new op is accepted every enabled cycle, including CALL immediately followed by RET. That RET returns the just-pushed address.

## Test plan
- Default params: reset, then 64 INC cycles with `en`=1 -> `pc` steps 0,1,...,63, then 0. `wrap`=1 only in the cycle `pc` shows 0.
- At `pc`=10, BRANCH operand 6'h3D (-3) -> `pc`=7, `wrap`=0. At `pc`=2, BRANCH 6'h3D -> `pc`=63, `wrap`=1.
- At `pc`=5, CALL 40 -> `pc`=40, `stack_empty`=0. Then RET -> `pc`=6, `stack_empty`=1, `err`=0.
- Four CALLs to 20 starting at `pc`=0 -> `stack_full`=1. Fifth CALL at `pc`=20 -> `pc`=21, `err`=1, still full. Four RETs -> `pc` sequence 21,21,21,1, then empty. An extra RET -> INC, `err` stays 1.
- `en`=0 with `op`=JUMP 33 for 3 cycles -> `pc` unchanged, `wrap`=0. `rst_n`=0 during a CALL at depth 2 -> next cycle `pc`=0, `stack_empty`=1, `err`=0.
- WIDTH=8, STEP=4, RESET_PC=248: INC, INC, INC -> `pc` 252, 0 (`wrap`=1), 4 (`wrap`=0).

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with increment, relative branch, absolute jump,
// hold and a bounded call/return stack.
//   clk, rst_n        clock and synchronous active-low reset
//   en                advance enable; 0 holds all state and clears wrap
//   op, operand       operation (INC/BRANCH/JUMP/CALL/RET/HOLD) and its offset or target
//   pc, wrap          registered program counter and one-cycle wrap-around pulse
//   stack_empty/full  return stack occupancy flags
//   err               sticky stack overflow/underflow flag
module pc_sequencer #(
    parameter int WIDTH       = 6,
    parameter int STEP        = 1,
    parameter int RESET_PC    = 0,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] pc,
    output logic             wrap,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             err
);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int AW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
    localparam logic [2:0] OP_INC = 3'd0, OP_BRANCH = 3'd1, OP_JUMP = 3'd2, OP_CALL = 3'd3, OP_RET = 3'd4;

    logic [DW-1:0]    depth;
    logic [WIDTH-1:0] stack [2**AW];
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH:0]   br_sum;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    top_idx;

    // Carry out of the top bit of inc_sum is the unsigned wrap.
    assign inc_sum = {1'b0, pc} + (WIDTH+1)'(STEP);
    // One extra bit of the signed sum: bit WIDTH is set exactly when the
    // true result falls below 0 or above 2^WIDTH-1.
    assign br_sum = {1'b0, pc} + {operand[WIDTH-1], operand};
    assign push_idx = AW'(depth);
    assign top_idx = AW'(depth) - AW'(1);
    assign stack_empty = depth == '0;
    assign stack_full = depth == DW'(STACK_DEPTH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc    <= WIDTH'(RESET_PC);
            wrap  <= 1'b0;
            depth <= '0;
            err   <= 1'b0;
        end else if (!en) begin
            wrap <= 1'b0;
        end else begin
            case (op)
                OP_INC: {wrap, pc} <= inc_sum;
                OP_BRANCH: {wrap, pc} <= br_sum;
                OP_JUMP: begin
                    pc   <= operand;
                    wrap <= 1'b0;
                end
                OP_CALL: begin
                    if (stack_full) begin
                        {wrap, pc} <= inc_sum;
                        err        <= 1'b1;
                    end else begin
                        stack[push_idx] <= inc_sum[WIDTH-1:0];
                        pc              <= operand;
                        wrap            <= 1'b0;
                        depth           <= depth + DW'(1);
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        {wrap, pc} <= inc_sum;
                        err        <= 1'b1;
                    end else begin
                        pc    <= stack[top_idx];
                        wrap  <= 1'b0;
                        depth <= depth - DW'(1);
                    end
                end
                default: wrap <= 1'b0;
            endcase
        end
    end
endmodule
